// File: rtl/mips_mmio_bridge.sv
// MMIO bridge between the MIPS32 data port and data memory: output/input registers, compare timer, and wait-stated I/O reads.
// Memory path is combinational; I/O loads stall the core for IO_WAIT cycles, and I/O stores never stall.
module mips_mmio_bridge #(
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
    parameter int          NUM_OUT = 4,
    parameter int          NUM_IN  = 2,
    parameter int          IO_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            datamem_add,
    input  logic [31:0]            write_data,
    input  logic                   mem_write,
    input  logic                   mem_read,
    output logic [31:0]            datamem_readdata,
    output logic                   stall,
    output logic                   dm_mem_write,
    output logic [31:0]            dm_add,
    output logic [31:0]            dm_write_data,
    input  logic [31:0]            dm_readdata,
    output logic [NUM_OUT*32-1:0]  gpio_out,
    input  logic [NUM_IN*32-1:0]   gpio_in,
    output logic                   irq
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam logic [5:0] OFF_TCOUNT = 6'h20;
    localparam logic [5:0] OFF_TCMP   = 6'h21;
    localparam logic [5:0] OFF_TCTRL  = 6'h22;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [31:0]              rdat_q, rdat_d;
    logic [NUM_OUT-1:0][31:0] out_q, out_d;
    logic [NUM_IN-1:0][31:0]  in_q;
    logic [31:0]              tcount_q, tcount_d;
    logic [31:0]              tcmp_q, tcmp_d;
    logic                     en_q, en_d;
    logic                     pend_q, pend_d;

    logic        io_sel;
    logic        wr_io;
    logic [5:0]  off;
    logic [31:0] rd_val;
    logic        unused_addr_bits;

    assign io_sel           = (datamem_add[31:16] == IO_BASE[31:16]);
    assign off              = datamem_add[7:2];
    assign wr_io            = mem_write & io_sel;
    assign unused_addr_bits = ^{datamem_add[15:8], datamem_add[1:0]};

    assign dm_add        = datamem_add;
    assign dm_write_data = write_data;
    assign dm_mem_write  = mem_write & ~io_sel;
    assign gpio_out      = out_q;
    assign irq           = pend_q;

    always_comb begin
        rd_val = 32'h0;
        for (int k = 0; k < NUM_OUT; k++)
            if (off == 6'(k)) rd_val = out_q[k];
        for (int k = 0; k < NUM_IN; k++)
            if (off == 6'(16 + k)) rd_val = in_q[k];
        if (off == OFF_TCOUNT) rd_val = tcount_q;
        if (off == OFF_TCMP)   rd_val = tcmp_q;
        if (off == OFF_TCTRL)  rd_val = {30'h0, pend_q, en_q};
    end

    always_comb begin
        if (!io_sel)                 datamem_readdata = dm_readdata;
        else if (IO_WAIT == 0)       datamem_readdata = rd_val;
        else if (state_q == S_RESP)  datamem_readdata = rdat_q;
        else                         datamem_readdata = 32'h0;
    end

    always_comb begin
        out_d    = out_q;
        tcmp_d   = tcmp_q;
        en_d     = en_q;
        pend_d   = pend_q;
        tcount_d = tcount_q;
        if (wr_io) begin
            for (int k = 0; k < NUM_OUT; k++)
                if (off == 6'(k)) out_d[k] = write_data;
            if (off == OFF_TCMP) tcmp_d = write_data;
            if (off == OFF_TCTRL) begin
                en_d = write_data[0];
                if (write_data[1]) pend_d = 1'b0;
            end
        end
        // Match-set is evaluated after the W1C so a simultaneous set wins.
        if (wr_io && off == OFF_TCOUNT) begin
            tcount_d = write_data;
        end else if (en_q && tcount_q == tcmp_q) begin
            tcount_d = 32'h0;
            pend_d   = 1'b1;
        end else if (en_q) begin
            tcount_d = tcount_q + 32'd1;
        end
    end

    // The request cycle is the first stall cycle, so WAIT lasts IO_WAIT-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdat_d  = rdat_q;
        stall   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (IO_WAIT > 0 && io_sel && mem_read) begin
                    stall  = 1'b1;
                    rdat_d = rd_val;
                    cnt_d  = 4'(IO_WAIT - 1);
                    state_d = (IO_WAIT == 1) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                stall  = 1'b1;
                rdat_d = rd_val;
                if (cnt_q == 4'd1) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'h0;
            rdat_q   <= 32'h0;
            out_q    <= '0;
            in_q     <= '0;
            tcount_q <= 32'h0;
            tcmp_q   <= 32'hFFFF_FFFF;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdat_q   <= rdat_d;
            out_q    <= out_d;
            in_q     <= gpio_in;
            tcount_q <= tcount_d;
            tcmp_q   <= tcmp_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: tb/tb_mips_mmio_bridge.sv
// Directed bench for mips_mmio_bridge built with IO_WAIT=3; inputs change and outputs are sampled around the falling edge.
module tb_mips_mmio_bridge;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   datamem_add;
    logic [31:0]   write_data;
    logic          mem_write;
    logic          mem_read;
    logic [31:0]   datamem_readdata;
    logic          stall;
    logic          dm_mem_write;
    logic [31:0]   dm_add;
    logic [31:0]   dm_write_data;
    logic [31:0]   dm_readdata;
    logic [127:0]  gpio_out;
    logic [63:0]   gpio_in;
    logic          irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk)
        if (dm_mem_write) mem[dm_add[7:2]] <= dm_write_data;
    assign dm_readdata = mem[dm_add[7:2]];

    mips_mmio_bridge #(
        .IO_BASE(32'hFFFF_0000), .NUM_OUT(4), .NUM_IN(2), .IO_WAIT(3)
    ) dut (
        .clk(clk), .rst(rst),
        .datamem_add(datamem_add), .write_data(write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .datamem_readdata(datamem_readdata), .stall(stall),
        .dm_mem_write(dm_mem_write), .dm_add(dm_add),
        .dm_write_data(dm_write_data), .dm_readdata(dm_readdata),
        .gpio_out(gpio_out), .gpio_in(gpio_in), .irq(irq)
    );

    // Starts just after a falling edge; returns at a later falling edge with strobes idle.
    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        datamem_add = addr;
        write_data  = data;
        mem_write   = 1'b1;
        @(negedge clk);
        mem_write   = 1'b0;
    endtask

    task automatic io_read(input logic [31:0] addr, output logic [31:0] data, output int stalls);
        datamem_add = addr;
        mem_read    = 1'b1;
        stalls      = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) break;
            stalls++;
            @(negedge clk);
        end
        data = datamem_readdata;
        total++;
        if (stall) begin
            bad++;
            $display("FAIL read_timeout addr=%h stall still high after %0d cycles", addr, stalls);
        end
        mem_read = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int s;
        rst = 1'b1; mem_write = 1'b0; mem_read = 1'b0;
        datamem_add = 32'h0; write_data = 32'h0; gpio_in = 64'h0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
        total++; if (gpio_out !== 128'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
        rst = 1'b0;
        @(negedge clk);
        io_read(32'hFFFF_0084, d, s);
        total++; if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL reset_tcmp got=%h exp=ffffffff", d); end
    endtask

    task automatic test_mem_path();
        logic [31:0] d;
        int s;
        datamem_add = 32'h0000_0010;
        write_data  = 32'h1234_5678;
        mem_write   = 1'b1;
        #1;
        total++; if (dm_mem_write !== 1'b1) begin bad++; $display("FAIL mem_store_strobe got=%b exp=1", dm_mem_write); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mem_store_stall got=%b exp=0", stall); end
        total++; if (dm_add !== 32'h10 || dm_write_data !== 32'h1234_5678) begin
            bad++; $display("FAIL mem_passthru got=%h/%h exp=00000010/12345678", dm_add, dm_write_data); end
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        total++; if (dm_mem_write !== 1'b0) begin bad++; $display("FAIL mem_strobe_one_cycle got=%b exp=0", dm_mem_write); end
        @(negedge clk);
        io_read(32'h0000_0010, d, s);
        total++; if (d !== 32'h1234_5678) begin bad++; $display("FAIL mem_load got=%h exp=12345678", d); end
        total++; if (s !== 0) begin bad++; $display("FAIL mem_load_stalls got=%0d exp=0", s); end
    endtask

    task automatic test_out_write();
        logic [31:0] d;
        int s;
        datamem_add = 32'hFFFF_0004;
        write_data  = 32'hA5A5_A5A5;
        mem_write   = 1'b1;
        #1;
        total++; if (dm_mem_write !== 1'b0) begin bad++; $display("FAIL io_store_dm_strobe got=%b exp=0", dm_mem_write); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL io_store_stall got=%b exp=0", stall); end
        @(negedge clk);
        mem_write = 1'b0;
        #1;
        total++; if (gpio_out[63:32] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL out1_value got=%h exp=a5a5a5a5", gpio_out[63:32]); end
        total++; if (gpio_out[31:0] !== 32'h0) begin bad++; $display("FAIL out0_untouched got=%h exp=0", gpio_out[31:0]); end
        io_read(32'hFFFF_0004, d, s);
        total++; if (d !== 32'hA5A5_A5A5) begin bad++; $display("FAIL out1_readback got=%h exp=a5a5a5a5", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int s;
        gpio_in = {32'h1111_2222, 32'h0000_CAFE};
        @(negedge clk);
        io_read(32'hFFFF_0040, d, s);
        total++; if (s !== 3) begin bad++; $display("FAIL in0_stalls got=%0d exp=3", s); end
        total++; if (d !== 32'h0000_CAFE) begin bad++; $display("FAIL in0_data got=%h exp=0000cafe", d); end
        io_read(32'hFFFF_0044, d, s);
        total++; if (s !== 3) begin bad++; $display("FAIL in1_stalls got=%0d exp=3", s); end
        total++; if (d !== 32'h1111_2222) begin bad++; $display("FAIL in1_data got=%h exp=11112222", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0]  d;
        logic [127:0] exp_out;
        int s;
        io_read(32'hFFFF_00F0, d, s);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", d); end
        io_read(32'hFFFF_0048, d, s);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL in2_unmapped_read got=%h exp=0", d); end
        io_write(32'hFFFF_00F0, 32'hDEAD_BEEF);
        io_write(32'hFFFF_0010, 32'h5555_5555);
        #1;
        exp_out = {32'h0, 32'h0, 32'hA5A5_A5A5, 32'h0};
        total++; if (gpio_out !== exp_out) begin bad++; $display("FAIL unmapped_write got=%h exp=%h", gpio_out, exp_out); end
        io_write(32'hFFFF_000C, 32'h0000_0033);
        #1;
        exp_out = {32'h33, 32'h0, 32'hA5A5_A5A5, 32'h0};
        total++; if (gpio_out !== exp_out) begin bad++; $display("FAIL out3_write got=%h exp=%h", gpio_out, exp_out); end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        int s;
        io_write(32'hFFFF_0084, 32'd5);
        io_write(32'hFFFF_0088, 32'd1);
        repeat (5) @(negedge clk);
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", irq); end
        @(negedge clk);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_on_match got=%b exp=1", irq); end
        // TCOUNT wrapped to 0 at the match; it has counted to 2 by the latching cycle.
        io_read(32'hFFFF_0080, d, s);
        total++; if (d !== 32'd2) begin bad++; $display("FAIL tcount_after_match got=%0d exp=2", d); end
        io_write(32'hFFFF_0088, 32'd2);
        #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c got=%b exp=0", irq); end
    endtask

    task automatic test_reset_in_wait();
        io_write(32'hFFFF_0080, 32'd5);
        io_write(32'hFFFF_0088, 32'd1);
        @(negedge clk);
        #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_preload got=%b exp=1", irq); end
        datamem_add = 32'hFFFF_0000;
        mem_read    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL wait2_stall got=%b exp=1", stall); end
        rst      = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_wait_stall got=%b exp=0", stall); end
        total++; if (gpio_out !== 128'h0) begin bad++; $display("FAIL rst_wait_gpio got=%h exp=0", gpio_out); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_wait_irq got=%b exp=0", irq); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        test_reset();
        test_mem_path();
        test_out_write();
        test_back_to_back();
        test_unmapped();
        test_timer();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
